cv32e40x_xif_offload_ctrl: RTL

Core-side initiator of the eXtension interface (XIF): takes custom-opcode instructions from the core's execute stage, offers them on the issue interface, drives the matching commit transaction for every issued instruction, tracks accepted in-flight instructions, and retires their results into the register file write port. It is the counterpart of the coprocessor-side responders (e.g. the AES32 unit) and sits between the ID/EX pipeline and the `if_xif` bundle.

---
 rtl/cv32e40x_xif_offload_ctrl_if.sv | 62 ++++++
 rtl/cv32e40x_xif_offload_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_xif_offload_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_xif : eXtension interface bundle shared by the core-side offload
// controller and the coprocessor-side responders.
//
// Channels
//   issue  : issue_valid / issue_ready, issue_req {instr, rs[1:0], rs_valid, id},
//            issue_resp {accept, writeback}
//   commit : commit_valid, commit {id, kill}
//   result : result_valid / result_ready, result {id, data, rd, we, exc}
// ----------------------------------------------------------------------------
interface if_xif #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32,
    parameter int X_RFW_WIDTH = 32
);

    typedef struct packed {
        logic [31:0]                  instr;
        logic [1:0][X_RFR_WIDTH-1:0]  rs;
        logic [2:0]                   rs_valid;
        logic [X_ID_WIDTH-1:0]        id;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic                   exc;
    } x_result_t;

    logic          issue_valid;
    logic          issue_ready;
    x_issue_req_t  issue_req;
    x_issue_resp_t issue_resp;

    logic          commit_valid;
    x_commit_t     commit;

    logic          result_valid;
    logic          result_ready;
    x_result_t     result;

    modport cpu_issue     (output issue_valid, issue_req, input  issue_ready, issue_resp);
    modport cpu_commit    (output commit_valid, commit);
    modport cpu_result    (input  result_valid, result, output result_ready);

    modport coproc_issue  (input  issue_valid, issue_req, output issue_ready, issue_resp);
    modport coproc_commit (input  commit_valid, commit);
    modport coproc_result (output result_valid, result, input  result_ready);

endinterface

// File: rtl/cv32e40x_xif_offload_ctrl.sv
// ----------------------------------------------------------------------------
// cv32e40x_xif_offload_ctrl : core-side XIF initiator.
//
// Offers execute-stage custom instructions on the issue channel, produces one
// commit per issued ID in the following cycle, tracks accepted writeback
// instructions in an in-order scoreboard and retires their results into a
// registered register-file write port.
//
// Ports
//   clk_i, rst_n          clock, asynchronous active-low reset
//   offload_valid_i       execute stage presents an instruction
//   offload_ready_o       issue handshake this cycle (instruction consumed)
//   offload_instr_i       instruction word
//   offload_rs1_i/rs2_i   operand values
//   flush_i               kills the instruction being committed
//   offload_illegal_o     handshake with accept = 0
//   busy_o                scoreboard non-empty or commit pending
//   rf_busy_i             core owns the RF write port this cycle
//   rf_we_o/waddr/wdata   registered RF write port
//   protocol_err_o        sticky result-protocol violation
//   xif_issue/commit/result  XIF channels (cpu side)
// ----------------------------------------------------------------------------
module cv32e40x_xif_offload_ctrl #(
    parameter int X_ID_WIDTH      = 4,
    parameter int X_RFR_WIDTH     = 32,
    parameter int X_RFW_WIDTH     = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   offload_valid_i,
    output logic                   offload_ready_o,
    input  logic [31:0]            offload_instr_i,
    input  logic [X_RFR_WIDTH-1:0] offload_rs1_i,
    input  logic [X_RFR_WIDTH-1:0] offload_rs2_i,
    input  logic                   flush_i,
    output logic                   offload_illegal_o,
    output logic                   busy_o,
    input  logic                   rf_busy_i,
    output logic                   rf_we_o,
    output logic [4:0]             rf_waddr_o,
    output logic [X_RFW_WIDTH-1:0] rf_wdata_o,
    output logic                   protocol_err_o,
    if_xif.cpu_issue               xif_issue,
    if_xif.cpu_commit              xif_commit,
    if_xif.cpu_result              xif_result
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int DEPTH = 2 ** PTR_W;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [X_ID_WIDTH-1:0] id_cnt;
    logic                  issue_hs;
    logic                  full;

    logic                  commit_vld_p1;
    logic                  commit_kill_p1;
    logic                  commit_wb_p1;
    logic [X_ID_WIDTH-1:0] commit_id_p1;
    logic [4:0]            commit_rd_p1;
    logic                  commit_kill;

    logic [X_ID_WIDTH-1:0] fifo_id [DEPTH];
    logic [4:0]            fifo_rd [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  push;
    logic                  res_hs;
    logic                  head_match;
    logic                  pop;

    // ---- stage p0: issue ----
    // A commit still in flight may push, so it reserves a slot; full can then
    // only rise on a handshake or a push, never while a request is waiting.
    assign full = (count == MAX_CNT) || (commit_vld_p1 && (count == MAX_CNT - 1'b1));

    assign xif_issue.issue_valid = offload_valid_i && !full;
    assign issue_hs              = xif_issue.issue_valid && xif_issue.issue_ready;
    assign offload_ready_o       = issue_hs;
    assign offload_illegal_o     = issue_hs && !xif_issue.issue_resp.accept;

    always_comb begin
        xif_issue.issue_req.instr    = offload_instr_i;
        xif_issue.issue_req.rs[0]    = offload_rs1_i;
        xif_issue.issue_req.rs[1]    = offload_rs2_i;
        xif_issue.issue_req.rs_valid = 3'b011;
        xif_issue.issue_req.id       = id_cnt;
    end

    // ---- stage p1: commit and scoreboard push ----
    // Flush is honoured both in the handshake cycle (captured) and live here.
    assign commit_kill             = commit_kill_p1 || flush_i;
    assign xif_commit.commit_valid = commit_vld_p1;

    always_comb begin
        xif_commit.commit.id   = commit_id_p1;
        xif_commit.commit.kill = commit_kill;
    end

    assign push = commit_vld_p1 && commit_wb_p1 && !commit_kill;

    // ---- result retire ----
    assign xif_result.result_ready = !rf_busy_i;
    assign res_hs     = xif_result.result_valid && xif_result.result_ready;
    assign head_match = (count != '0)
                     && (fifo_id[rd_ptr] == xif_result.result.id)
                     && (fifo_rd[rd_ptr] == xif_result.result.rd);
    assign pop        = res_hs && head_match;

    assign busy_o = (count != '0) || commit_vld_p1;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            id_cnt         <= '0;
            commit_vld_p1  <= 1'b0;
            commit_kill_p1 <= 1'b0;
            commit_wb_p1   <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rf_we_o        <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            commit_vld_p1 <= issue_hs;
            if (issue_hs) begin
                id_cnt         <= id_cnt + 1'b1;
                commit_kill_p1 <= !xif_issue.issue_resp.accept || flush_i;
                commit_wb_p1   <= xif_issue.issue_resp.accept && xif_issue.issue_resp.writeback;
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Exception results are popped but never written back.
            rf_we_o <= pop && xif_result.result.we && !xif_result.result.exc
                           && (xif_result.result.rd != 5'd0);
            if (res_hs && (!head_match || xif_result.result.exc)) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue_hs) begin
            commit_id_p1 <= id_cnt;
            commit_rd_p1 <= offload_instr_i[11:7];
        end
        if (push) begin
            fifo_id[wr_ptr] <= commit_id_p1;
            fifo_rd[wr_ptr] <= commit_rd_p1;
        end
        if (pop) begin
            rf_waddr_o <= xif_result.result.rd;
            rf_wdata_o <= xif_result.result.data;
        end
    end

endmodule
